alu: RTL and testbench
======================

Name: alu

Overview:
- Integer ALU for the 32-bit single-cycle/multicycle MIPS datapath.
- Computes AND, OR, ADD or SUB of two operands, selected by a 2-bit control from ALU control decode.
- Result and status flags are registered: one clock of latency.
- Zero drives the branch-equal decision; the extra flags are available to the exception/compare logic.

Parameters:
- WIDTH, 32, operand/result bit width (must be >= 2).

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- Operand1  in  WIDTH  operand A (rs / base).
- Operand2  in  WIDTH  operand B (rt / immediate).
- ALUControl  in  2  operation select: 00 AND, 01 OR, 10 ADD, 11 SUB.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  registered; 1 when ALUResult == 0.
- Carry  out  1  registered carry-out (ADD/SUB only).
- Overflow  out  1  registered signed overflow (ADD/SUB only).
- Negative  out  1  registered ALUResult[WIDTH-1].

Behaviour:
- Reset (async assert, any time): ALUResult=0, Zero=1, Carry=0, Overflow=0, Negative=0. Held while reset=1; first capture on the first rising clk after deassert.
- Reset mid-operation discards the in-flight result; no partial state survives.
- Combinational next-value on each rising clk (reset=0):
  - 00: A & B bitwise.
  - 01: A | B bitwise.
  - 10: A + B modulo 2^WIDTH. Carry = bit WIDTH of the (WIDTH+1)-bit sum. Overflow = A[msb]==B[msb] && R[msb]!=A[msb].
  - 11: A - B computed as A + ~B + 1 modulo 2^WIDTH. Carry = carry-out of that sum (1 = no borrow, i.e. A >= B unsigned). Overflow = A[msb]!=B[msb] && R[msb]!=A[msb].
- AND/OR: Carry=0, Overflow=0.
- Zero = (next result == 0), Negative = next result MSB; both registered in the same cycle as ALUResult.
- Latency: inputs sampled at edge N appear on outputs after edge N. One new operation every cycle, no stall or handshake.
- Outputs hold between edges; operand changes between edges have no effect until the next edge.
- No X propagation: every ALUControl code is defined, with no default/illegal case.
- Wrap-around: ADD of 0xFFFFFFFF + 1 -> result 0, Zero=1, Carry=1, Overflow=0.

Decomposition:
- Package alu_pkg: localparams ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11, and the WIDTH default.
- One sub-module, alu_addsub: shared adder taking A, B and a sub flag; returns sum, carry-out and overflow.
- The top level holds the logic ops, the result mux, flag generation and output registers.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with nonzero outputs -> immediately ALUResult=0, Zero=1, Carry/Overflow/Negative=0.
- A=0x00000055, B=0x000040AA:
  - AND -> 0x00000000, Zero=1.
  - OR -> 0x000040FF, Zero=0.
  - ADD -> 0x000040FF, Carry=0, Overflow=0.
  - Each result is valid one clk after it is applied.
- SUB, same operands -> 0xFFFFBFAB, Negative=1, Carry=0, Overflow=0, Zero=0.
- SUB, A=B=0x00000055 -> 0x00000000, Zero=1, Carry=1, Overflow=0.
- ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, Overflow=1, Negative=1.
- ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, Carry=1, Zero=1.
- Back-to-back ALUControl change every cycle with random operands -> outputs match the reference model delayed by exactly one clk.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the MIPS integer ALU: operation encodings and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: computes A + B or A + ~B + 1.
// Also produces the carry-out and the signed overflow flag.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    assign b_eff    = sub_i ? ~b_i : b_i;
    assign full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

    assign sum_o   = full_sum[WIDTH-1:0];
    assign carry_o = full_sum[WIDTH];

    // Overflow occurs when the effective operands agree in sign but the sum does not.
    // With b inverted, this covers both the add case and the subtract case.
    assign overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (full_sum[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered MIPS integer ALU: AND/OR/ADD/SUB with Zero, Carry, Overflow and Negative flags.
// There is one clock of latency from the operands to the outputs.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
);

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_q, negative_q;

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i        (Operand1),
        .b_i        (Operand2),
        .sub_i      (ALUControl == ALU_SUB),
        .sum_o      (as_sum),
        .carry_o    (as_carry),
        .overflow_o (as_overflow)
    );

    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (ALUControl)
            ALU_AND: result_d = Operand1 & Operand2;
            ALU_OR:  result_d = Operand1 | Operand2;
            ALU_ADD, ALU_SUB: begin
                result_d   = as_sum;
                carry_d    = as_carry;
                overflow_d = as_overflow;
            end
        endcase
    end

    // A reset value of Zero=1 keeps the flag consistent with the cleared result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= (result_d == '0);
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= result_d[WIDTH-1];
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Carry     = carry_q;
    assign Overflow  = overflow_q;
    assign Negative  = negative_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Observed word is {ALUResult, Zero, Carry, Overflow, Negative}.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Operand1, Operand2;
    logic [1:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero, Carry, Overflow, Negative;
    logic [35:0] obs;

    int total = 0;
    int bad   = 0;

    localparam logic [35:0] RESET_EXP = {32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Operand1   (Operand1),
        .Operand2   (Operand2),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .Negative   (Negative)
    );

    always #5 clk = ~clk;

    assign obs = {ALUResult, Zero, Carry, Overflow, Negative};

    // Reference built from 64-bit signed/unsigned arithmetic rather than an adder chain.
    function automatic logic [35:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        c, v;
        longint      sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: begin
                r  = a + b;
                c  = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            default: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        endcase
        return {r, (r == 32'h0), c, v, r[31]};
    endfunction

    task automatic test_reset();
        reset      = 1'b1;
        Operand1   = 32'h0;
        Operand2   = 32'h0;
        ALUControl = 2'b00;
        #3;
        total++;
        if (obs !== RESET_EXP) begin
            bad++;
            $display("FAIL reset_initial: got %h expected %h", obs, RESET_EXP);
        end
        @(negedge clk);
        reset      = 1'b0;
        Operand1   = 32'hFFFF_FFFF;
        Operand2   = 32'hFFFF_FFFF;
        ALUControl = 2'b10;
        @(negedge clk);
        total++;
        if (obs !== {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_preload: got %h expected %h", obs,
                     {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== RESET_EXP) begin
            bad++;
            $display("FAIL reset_async: got %h expected %h", obs, RESET_EXP);
        end
        @(posedge clk);
        #1;
        total++;
        if (obs !== RESET_EXP) begin
            bad++;
            $display("FAIL reset_held: got %h expected %h", obs, RESET_EXP);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_capture: got %h expected %h", obs,
                     {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_ops();
        logic [1:0]  op  [3] = '{2'b00, 2'b01, 2'b10};
        logic [35:0] exp [3] = '{{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0},
                                 {32'h0000_40FF, 1'b0, 1'b0, 1'b0, 1'b0},
                                 {32'h0000_40FF, 1'b0, 1'b0, 1'b0, 1'b0}};
        logic [35:0] prev;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            prev       = obs;
            Operand1   = 32'h0000_0055;
            Operand2   = 32'h0000_40AA;
            ALUControl = op[i];
            #1;
            total++;
            if (obs !== prev) begin
                bad++;
                $display("FAIL basic_hold[%0d]: got %h expected %h", i, obs, prev);
            end
            @(negedge clk);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL basic_op%0d: got %h expected %h", op[i], obs, exp[i]);
            end
            $display("op=%0d A=%h B=%h -> %h", op[i], Operand1, Operand2, obs);
        end
    endtask

    task automatic test_arith_edges();
        logic [1:0]  op  [5] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [31:0] a   [5] = '{32'h0000_0055, 32'h0000_0055, 32'h7FFF_FFFF,
                                 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] b   [5] = '{32'h0000_40AA, 32'h0000_0055, 32'h0000_0001,
                                 32'h0000_0001, 32'h0000_0001};
        logic [35:0] exp [5] = '{{32'hFFFF_BFAB, 1'b0, 1'b0, 1'b0, 1'b1},
                                 {32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0},
                                 {32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1},
                                 {32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0},
                                 {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Operand1   = a[i];
            Operand2   = b[i];
            ALUControl = op[i];
            @(negedge clk);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL arith_edge[%0d]: got %h expected %h", i, obs, exp[i]);
            end
            $display("op=%0d A=%h B=%h -> %h", op[i], a[i], b[i], obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        @(negedge clk);
        Operand1   = $urandom;
        Operand2   = $urandom;
        ALUControl = 2'b00;
        exp        = ref_model(ALUControl, Operand1, Operand2);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b[%0d]: got %h expected %h", i - 1, obs, exp);
            end
            $display("b2b[%0d] -> %h", i - 1, obs);
            Operand1   = $urandom;
            Operand2   = (i % 5 == 0) ? Operand1 : $urandom;
            ALUControl = 2'(i % 4);
            exp        = ref_model(ALUControl, Operand1, Operand2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_arith_edges();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
